alu_result_bcd: RTL and testbench

Sequential binary-to-BCD converter directly downstream of the 16-bit four-function ALU. On a start strobe it captures the ALU result word and overflow flag, then runs a shift-and-add-3 (double-dabble) conversion over WIDTH cycles. It presents five packed BCD digits, plus sign and error flags, to the seven-segment display driver.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_result_bcd_if.sv | 36 +++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/alu_result_bcd.sv | 158 +++++++++++++++
 tb/tb_alu_result_bcd.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result -> BCD conversion block.
//   - state_t     : conversion FSM states (IDLE / SHIFT / DONE)
//   - ALU_WIDTH   : width of the ALU result word
//   - BCD_DIGITS  : number of packed BCD digits presented to the display
//   - bcd_fits()  : true when DIGITS decimal digits can hold any WIDTH-bit value
// Optional feature macro used by the block: ALU_BCD_SIGNED_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH  = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Elaboration-time sanity check: 10^digits must exceed 2^width.
    function automatic bit bcd_fits(input int width, input int digits);
        longint unsigned pow10;
        longint unsigned pow2;
        pow10 = 1;
        pow2  = 1;
        for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
        for (int i = 0; i < width; i++)  pow2  = pow2 * 2;
        return pow10 > pow2;
    endfunction

endpackage

// File: rtl/alu_result_bcd_if.sv
// -----------------------------------------------------------------------------
// alu_result_bcd_if
// Bundle between the ALU side (master: issues conversion requests and consumes
// the display result) and the converter (slave).
//   start   : conversion request, sampled only while busy=0
//   din     : ALU result word
//   ovf_in  : ALU overflow flag, captured with din
//   busy    : conversion in progress
//   done    : one-cycle pulse, bcd/neg/err updated in that cycle
//   bcd     : packed BCD, digit 0 (units) in bits [3:0]
//   neg     : result negative (only meaningful with ALU_BCD_SIGNED_EN)
//   err     : captured overflow; bcd forced to zero
// -----------------------------------------------------------------------------
interface alu_result_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      din;
    logic                  ovf_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  err;

    modport master (
        output start, din, ovf_in,
        input  busy, done, bcd, neg, err
    );

    modport slave (
        input  start, din, ovf_in,
        output busy, done, bcd, neg, err
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell: adds 3 to a BCD digit that is
// 5 or more, so that the following left shift carries correctly into the next
// decimal digit.
//   d_i : working digit before the shift
//   d_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end
    end
endmodule

// File: rtl/alu_result_bcd.sv
// -----------------------------------------------------------------------------
// alu_result_bcd
// Sequential binary-to-BCD converter placed after the 16-bit ALU. A start
// request captures the result word and the overflow flag; a shift-and-add-3
// loop then runs for WIDTH cycles and the packed digits, sign and error flag
// are published with a one-cycle done pulse.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (wins over start)
//   bus  : alu_result_bcd_if.slave (start/din/ovf_in in, busy/done/bcd/neg/err out)
//
// Build option:
//   ALU_BCD_SIGNED_EN defined   -> din is two's complement; negative values
//                                  are converted by magnitude and neg is set.
//   ALU_BCD_SIGNED_EN undefined -> din is unsigned; neg is tied low.
// -----------------------------------------------------------------------------
module alu_result_bcd
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic            clk,
    input  logic            rst,
    alu_result_bcd_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    if (!bcd_fits(WIDTH, DIGITS)) begin : g_bad_cfg
        $error("alu_result_bcd: DIGITS too small for WIDTH");
    end

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sh_q,    sh_d;
    logic [BW-1:0]   wbcd_q,  wbcd_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            err_lat_q, err_lat_d;
    logic [BW-1:0]   bcd_q,   bcd_d;
    logic            err_q,   err_d;
    logic [BW-1:0]   wbcd_adj;
`ifdef ALU_BCD_SIGNED_EN
    logic            sign_q,  sign_d;
    logic            neg_q,   neg_d;
    logic signed [WIDTH-1:0] din_s;

    assign din_s = $signed(bus.din);
`endif

    // Add-3 correction for every working digit ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (wbcd_q[4*g +: 4]),
            .d_o (wbcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        wbcd_d    = wbcd_q;
        cnt_d     = cnt_q;
        err_lat_d = err_lat_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
`ifdef ALU_BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // DONE also accepts start so conversions can run back to back.
                if (bus.start) begin
                    err_lat_d = bus.ovf_in;
                    wbcd_d    = '0;
                    cnt_d     = '0;
`ifdef ALU_BCD_SIGNED_EN
                    // Negate is a plain WIDTH-bit negate: the most negative
                    // value maps onto its own bit pattern, read as unsigned.
                    if (din_s < 0) begin
                        sh_d   = $unsigned(-din_s);
                        sign_d = 1'b1;
                    end else begin
                        sh_d   = bus.din;
                        sign_d = 1'b0;
                    end
`else
                    sh_d = bus.din;
`endif
                    state_d = bus.ovf_in ? DONE : SHIFT;
                end
            end

            SHIFT: begin
                {wbcd_d, sh_d} = {wbcd_adj, sh_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Published outputs are loaded on the edge that enters DONE so they
        // are already valid while done is high.
        if (state_d == DONE) begin
            bcd_d = err_lat_d ? '0 : wbcd_d;
            err_d = err_lat_d;
`ifdef ALU_BCD_SIGNED_EN
            neg_d = sign_d & ~err_lat_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            wbcd_q    <= '0;
            cnt_q     <= '0;
            err_lat_q <= 1'b0;
            bcd_q     <= '0;
            err_q     <= 1'b0;
`ifdef ALU_BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            wbcd_q    <= wbcd_d;
            cnt_q     <= cnt_d;
            err_lat_q <= err_lat_d;
            bcd_q     <= bcd_d;
            err_q     <= err_d;
`ifdef ALU_BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.bcd  = bcd_q;
    assign bus.err  = err_q;
`ifdef ALU_BCD_SIGNED_EN
    assign bus.neg  = neg_q;
`else
    assign bus.neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_alu_result_bcd
// Directed, table-driven bench for alu_result_bcd plus hand-written sequences
// for start-during-SHIFT, back-to-back start and reset mid-conversion.
// Expected values for the sign-sensitive vectors follow ALU_BCD_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_alu_result_bcd;

    localparam int W = 16;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_result_bcd_if #(.WIDTH(W), .DIGITS(D)) bus_if ();

    alu_result_bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        string       name;
        logic [15:0] din;
        logic        ovf;
        logic [19:0] bcd;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs[10];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the negedge of cycle k+1.
    task automatic pulse(input logic [15:0] d, input logic o);
        @(negedge clk);
        bus_if.start  = 1'b1;
        bus_if.din    = d;
        bus_if.ovf_in = o;
        @(negedge clk);
        bus_if.start  = 1'b0;
    endtask

    // Called at the negedge of cycle k+1; waits (bounded) for done.
    task automatic wait_done(output int cyc, output int nb);
        cyc = 1;
        nb  = 0;
        while (!bus_if.done && cyc < 40) begin
            if (bus_if.busy) nb++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input int cyc, input int nb,
                                input int exp_cyc, input int exp_nb,
                                input logic [19:0] b, input logic n, input logic e);
        chk({name, ".latency"}, cyc, exp_cyc);
        chk({name, ".busy_cycles"}, nb, exp_nb);
        chk({name, ".busy_at_done"}, {31'd0, bus_if.busy}, 32'd0);
        chk({name, ".bcd"}, {12'd0, bus_if.bcd}, {12'd0, b});
        chk({name, ".neg"}, {31'd0, bus_if.neg}, {31'd0, n});
        chk({name, ".err"}, {31'd0, bus_if.err}, {31'd0, e});
    endtask

    initial begin
        int cyc;
        int nb;
        int seen_done;
        int seen_busy;

        vecs[0] = '{"v12345", 16'd12345, 1'b0, 20'h12345, 1'b0, 1'b0};
`ifdef ALU_BCD_SIGNED_EN
        vecs[1] = '{"vFFFF",  16'hFFFF,  1'b0, 20'h00001, 1'b1, 1'b0};
        vecs[2] = '{"v8000",  16'h8000,  1'b0, 20'h32768, 1'b1, 1'b0};
        vecs[9] = '{"vFF85",  16'hFF85,  1'b0, 20'h00123, 1'b1, 1'b0};
`else
        vecs[1] = '{"vFFFF",  16'hFFFF,  1'b0, 20'h65535, 1'b0, 1'b0};
        vecs[2] = '{"v8000",  16'h8000,  1'b0, 20'h32768, 1'b0, 1'b0};
        vecs[9] = '{"vFF85",  16'hFF85,  1'b0, 20'h65413, 1'b0, 1'b0};
`endif
        vecs[3] = '{"ovf999", 16'd999,   1'b1, 20'h00000, 1'b0, 1'b1};
        vecs[4] = '{"zero",   16'd0,     1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[5] = '{"v42",    16'd42,    1'b0, 20'h00042, 1'b0, 1'b0};
        vecs[6] = '{"v9999",  16'd9999,  1'b0, 20'h09999, 1'b0, 1'b0};
        vecs[7] = '{"v10000", 16'd10000, 1'b0, 20'h10000, 1'b0, 1'b0};
        vecs[8] = '{"v1",     16'd1,     1'b0, 20'h00001, 1'b0, 1'b0};

        bus_if.start  = 1'b0;
        bus_if.din    = '0;
        bus_if.ovf_in = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst.done", {31'd0, bus_if.done}, 32'd0);
        chk("rst.bcd",  {12'd0, bus_if.bcd}, 32'd0);
        chk("rst.neg",  {31'd0, bus_if.neg}, 32'd0);
        chk("rst.err",  {31'd0, bus_if.err}, 32'd0);
        rst = 1'b0;

        // Table-driven conversions
        for (int i = 0; i < 10; i++) begin
            pulse(vecs[i].din, vecs[i].ovf);
            bus_if.ovf_in = 1'b0;
            wait_done(cyc, nb);
            check_result(vecs[i].name, cyc, nb, vecs[i].ovf ? 1 : 17, vecs[i].ovf ? 0 : 16,
                         vecs[i].bcd, vecs[i].neg, vecs[i].err);
            @(negedge clk);
            chk({vecs[i].name, ".done_pulse"}, {31'd0, bus_if.done}, 32'd0);
            chk({vecs[i].name, ".hold"}, {12'd0, bus_if.bcd}, {12'd0, vecs[i].bcd});
        end

        // start re-pulsed at SHIFT cycle 5 (with ovf_in raised) is ignored;
        // a start on the DONE cycle launches the next conversion.
        pulse(16'd12345, 1'b0);
        cyc = 1;
        nb  = 0;
        while (!bus_if.done && cyc < 40) begin
            if (bus_if.busy) nb++;
            if (cyc == 5) begin
                bus_if.start  = 1'b1;
                bus_if.din    = 16'd777;
                bus_if.ovf_in = 1'b1;
            end else if (cyc == 6) begin
                bus_if.start  = 1'b0;
                bus_if.ovf_in = 1'b0;
                bus_if.din    = 16'd31;
            end
            @(negedge clk);
            cyc++;
        end
        check_result("ignore", cyc, nb, 17, 16, 20'h12345, 1'b0, 1'b0);
        bus_if.start = 1'b1;
        bus_if.din   = 16'd54321;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(cyc, nb);
`ifdef ALU_BCD_SIGNED_EN
        check_result("b2b", cyc, nb, 17, 16, 20'h11215, 1'b1, 1'b0);
`else
        check_result("b2b", cyc, nb, 17, 16, 20'h54321, 1'b0, 1'b0);
`endif

        // Reset at SHIFT cycle 8 aborts without a done pulse.
        pulse(16'd4321, 1'b0);
        repeat (7) @(negedge clk);
        chk("abort.busy_before", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", {31'd0, bus_if.busy}, 32'd0);
        chk("abort.done", {31'd0, bus_if.done}, 32'd0);
        chk("abort.bcd",  {12'd0, bus_if.bcd}, 32'd0);
        chk("abort.neg",  {31'd0, bus_if.neg}, 32'd0);
        chk("abort.err",  {31'd0, bus_if.err}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done) seen_done++;
        end
        chk("abort.no_done", seen_done, 0);

        // rst and start together: start dropped.
        bus_if.start = 1'b1;
        bus_if.din   = 16'd5;
        rst          = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        rst          = 1'b0;
        seen_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.busy || bus_if.done) seen_busy++;
            @(negedge clk);
        end
        chk("rst_start.dropped", seen_busy, 0);

        pulse(16'd42, 1'b0);
        wait_done(cyc, nb);
        check_result("after_rst", cyc, nb, 17, 16, 20'h00042, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
